// File: rtl/amber128_uart_rx_pkg.sv
// rtl/amber128_uart_rx_pkg.sv - shared UART types and baud-rate helper for the amber128 RX/TX pair
package amber128_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Round-to-nearest clocks per bit; the transmitter uses the same derivation.
    function automatic int clks_per_bit(input int clock_freq_hz, input int baud_rate);
        return (clock_freq_hz + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/amber128_uart_rx_if.sv
// rtl/amber128_uart_rx_if.sv - received-byte stream plus error pulses
interface amber128_uart_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       frame_err;
    logic       overrun;

    modport master (output tdata, output tvalid, output frame_err, output overrun, input tready);
    modport slave  (input tdata, input tvalid, input frame_err, input overrun, output tready);
endinterface

// File: rtl/amber128_sync2.sv
// rtl/amber128_sync2.sv - generic two-flop synchroniser, synchronous active-high reset
module amber128_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/amber128_uart_rx_core.sv
// rtl/amber128_uart_rx_core.sv - 8N1 receive FSM and one-entry holding register
// Optional AMBER128_UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module amber128_uart_rx_core
    import amber128_uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    amber128_uart_rx_if.master   rx_if
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $fatal(1, "amber128_uart_rx: CLKS_PER_BIT must be at least 2");
    end

    logic rx_s;
    logic sample_d;

    amber128_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

`ifdef AMBER128_UART_RX_MAJORITY_EN
    if (CLKS_PER_BIT < 4) begin : g_maj_check
        $fatal(1, "amber128_uart_rx: majority sampling needs CLKS_PER_BIT >= 4");
    end

    // Two previous samples plus the live one form the three-sample vote window.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_d = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_d = rx_s;
`endif

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && rx_if.tready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!sample_d) begin
                        cnt_q     <= BIT_LOAD;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q <= {sample_d, shift_q[7:1]};
                        cnt_q   <= BIT_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (sample_d) begin
                        // Back to IDLE at mid-stop so the next start edge is caught early.
                        state_q <= IDLE;
                        if (!valid_q || rx_if.tready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.tdata     = data_q;
    assign rx_if.tvalid    = valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
endmodule

// File: rtl/amber128_uart_rx.sv
// rtl/amber128_uart_rx.sv - amber128 8N1 UART receiver top
// Optional AMBER128_UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module amber128_uart_rx
    import amber128_uart_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 27_000_000,
    parameter int BAUD_RATE     = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);
    amber128_uart_rx_if u_if ();

    amber128_uart_rx_core #(
        .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
        .BAUD_RATE     (BAUD_RATE)
    ) u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .rx_if (u_if.master)
    );

    assign u_if.tready = ready_i;
    assign data_o      = u_if.tdata;
    assign valid_o     = u_if.tvalid;
    assign frame_err_o = u_if.frame_err;
    assign overrun_o   = u_if.overrun;
endmodule
